// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed 8-digit scan controller.
// Define SCAN_BLANK_EN to insert BLANK_CYC dark cycles between digits. Without it, digits
// change back to back and digit_on stays high while scanning.
module digit_scan_ctrl #(
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 10,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  digit_mask,
  input  logic [31:0] digit_data,
  output logic [2:0]  N,
  output logic [3:0]  nibble,
  output logic        digit_on,
  output logic        frame_done
);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       n_q, n_d, nxt, first;
  logic [3:0]       nib_q, nib_d;
  logic             on_q, on_d, fd_q, fd_d;
  // lowest set bit strictly above i, else lowest set bit overall; next_idx(m, 7) is the lowest set bit
  function automatic logic [2:0] next_idx(input logic [7:0] m, input logic [2:0] i);
    logic [2:0] lo, up;
    logic       hit;
    lo  = '0;
    up  = '0;
    hit = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) lo = 3'(k);
      if (m[k] && 3'(k) > i) begin
        up  = 3'(k);
        hit = 1'b1;
      end
    end
    return hit ? up : lo;
  endfunction
  assign nxt   = next_idx(digit_mask, n_q);
  assign first = next_idx(digit_mask, 3'd7);
  // next-state: abort has priority; N advances on SHOW exit so the decoder settles while dark
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    nib_d   = nib_q;
    on_d    = on_q;
    fd_d    = 1'b0;
    if (state_q != IDLE && (!en || digit_mask == '0)) begin
      state_d = IDLE;
      on_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (en && digit_mask != '0) begin
          state_d = SHOW;
          n_d     = first;
          nib_d   = digit_data[{first, 2'b00} +: 4];
          on_d    = 1'b1;
          cnt_d   = '0;
        end
        SHOW: if (cnt_q == SHOW_END) begin
          n_d   = nxt;
          cnt_d = '0;
          fd_d  = nxt <= n_q;
`ifdef SCAN_BLANK_EN
          state_d = BLANK;
          on_d    = 1'b0;
`else
          nib_d = digit_data[{nxt, 2'b00} +: 4];
`endif
        end else cnt_d = cnt_q + 1'b1;
        BLANK: if (cnt_q == BLANK_END) begin
          state_d = SHOW;
          nib_d   = digit_data[{n_q, 2'b00} +: 4];
          on_d    = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      nib_q   <= '0;
      on_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      nib_q   <= nib_d;
      on_q    <= on_d;
      fd_q    <= fd_d;
    end
  end
  assign N          = n_q;
  assign nibble     = nib_q;
  assign digit_on   = on_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed checks of digit_scan_ctrl with SHOW_CYC=4, BLANK_CYC=2.
module tb_digit_scan_ctrl;
`ifdef SCAN_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif
  localparam int P = 4 + BL;
  logic        clk = 1'b0, run = 1'b0, rst_n = 1'b1, en = 1'b0;
  logic [7:0]  digit_mask = '0;
  logic [31:0] digit_data = '0;
  logic [2:0]  N;
  logic [3:0]  nibble;
  logic        digit_on, frame_done;
  int          vectors = 0, miscompares = 0;

  digit_scan_ctrl #(.SHOW_CYC(4), .BLANK_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask), .digit_data(digit_data),
    .N(N), .nibble(nibble), .digit_on(digit_on), .frame_done(frame_done)
  );

  always #5 if (run) clk = ~clk;

  task automatic stop_scan();
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // seq holds the frame's digit order as 3-bit fields; data switches d0 -> d1 during the first SHOW
  task automatic run_scan(input string name, input logic [7:0] m, input logic [31:0] d0,
                          input logic [31:0] d1, input logic [23:0] seq, input int len, input int ncyc);
    int d, p;
    logic [2:0]  cur, nx, en_n;
    logic [31:0] dat;
    logic [3:0]  en_nib;
    logic        en_on, en_fd;
    @(negedge clk);
    digit_mask = m;
    digit_data = d0;
    en = 1'b1;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      d = t / P;
      p = t % P;
      cur = seq[3*(d%len) +: 3];
      nx  = seq[3*((d+1)%len) +: 3];
      en_n = p < 4 ? cur : nx;
      dat = d == 0 ? d0 : d1;
      en_nib = dat[4*cur +: 4];
      en_on = p < 4;
      en_fd = t >= 4 && (t - 4) % P == 0 && ((t - 4) / P) % len == len - 1;
      vectors += 4;
      if (N !== en_n) begin
        miscompares++;
        $display("FAIL %s t=%0d N got %0d expected %0d", name, t, N, en_n);
      end
      if (nibble !== en_nib) begin
        miscompares++;
        $display("FAIL %s t=%0d nibble got %h expected %h", name, t, nibble, en_nib);
      end
      if (digit_on !== en_on) begin
        miscompares++;
        $display("FAIL %s t=%0d digit_on got %b expected %b", name, t, digit_on, en_on);
      end
      if (frame_done !== en_fd) begin
        miscompares++;
        $display("FAIL %s t=%0d frame_done got %b expected %b", name, t, frame_done, en_fd);
      end
      if (t == 1) digit_data = d1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    vectors++;
    if ({N, nibble, digit_on, frame_done} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_noclk outputs got %b expected 0", {N, nibble, digit_on, frame_done});
    end
    run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_scan("reset_pre", 8'hA4, 32'h76543210, 32'h76543210, 24'o752, 3, 3);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({N, nibble, digit_on, frame_done} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_async outputs got %b expected 0", {N, nibble, digit_on, frame_done});
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_mask();
    run_scan("full_mask", 8'hFF, 32'h76543210, 32'h76543210, 24'o76543210, 8, 16 * P);
    stop_scan();
  endtask

  task automatic test_sparse_data();
    run_scan("sparse", 8'hA4, 32'hFEDCBA98, 32'h01234567, 24'o752, 3, 6 * P);
    stop_scan();
  endtask

  task automatic test_single_mask_change();
    run_scan("single", 8'h10, 32'h76543210, 32'h76543210, 24'o4, 1, 2 * P);
    @(negedge clk);
    digit_mask = 8'h02;
    repeat (3) @(negedge clk);
    vectors += 2;
    if (N !== 3'd4 || digit_on !== 1'b1) begin
      miscompares++;
      $display("FAIL mask_change_finish N=%0d on=%b expected N=4 on=1", N, digit_on);
    end
    @(negedge clk);
    if (N !== 3'd1 || frame_done !== 1'b1 || digit_on !== (BL == 0)) begin
      miscompares++;
      $display("FAIL mask_change_next N=%0d fd=%b on=%b expected N=1 fd=1 on=%b",
               N, frame_done, digit_on, BL == 0);
    end
    stop_scan();
  endtask

  task automatic test_abort();
    run_scan("abort_pre", 8'hA4, 32'hFEDCBA98, 32'hFEDCBA98, 24'o752, 3, 2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (digit_on !== 1'b0 || N !== 3'd2 || nibble !== 4'hA || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_hold i=%0d on=%b N=%0d nib=%h fd=%b expected on=0 N=2 nib=a fd=0",
                 i, digit_on, N, nibble, frame_done);
      end
    end
    digit_mask = 8'h00;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (digit_on !== 1'b0 || N !== 3'd2) begin
        miscompares++;
        $display("FAIL zero_mask_idle i=%0d on=%b N=%0d expected on=0 N=2", i, digit_on, N);
      end
    end
    stop_scan();
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_data();
    test_single_mask_change();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
